// File: rtl/hysteresis_pkg.sv
// Shared types and default thresholds for the
// hysteresis edge-linking filter.
package hysteresis_pkg;

  typedef enum logic [1:0] {
    PROLOGUE,
    FILTER,
    OUTPUT
  } state_t;

  localparam int HYST_DEF_HIGH = 48;
  localparam int HYST_DEF_LOW  = 12;

endpackage

// File: rtl/window_shift_reg.sv
// Two-row-plus-three line buffer that exposes a
// 3x3 window; index 0 is the oldest pixel.
module window_shift_reg #(
  parameter int LEN        = 1443,
  parameter int PIXEL_BITS = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  shift_en,
  input  logic [PIXEL_BITS-1:0] din,
  output logic [PIXEL_BITS-1:0] tap_ul,
  output logic [PIXEL_BITS-1:0] tap_u,
  output logic [PIXEL_BITS-1:0] tap_ur,
  output logic [PIXEL_BITS-1:0] tap_l,
  output logic [PIXEL_BITS-1:0] tap_c,
  output logic [PIXEL_BITS-1:0] tap_r,
  output logic [PIXEL_BITS-1:0] tap_dl,
  output logic [PIXEL_BITS-1:0] tap_d,
  output logic [PIXEL_BITS-1:0] tap_dr
);

  localparam int W = (LEN - 3) / 2;

  logic [PIXEL_BITS-1:0] sr [LEN];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < LEN; i++)
        sr[i] <= '0;
    end else if (shift_en) begin
      for (int i = 0; i < LEN - 1; i++)
        sr[i] <= sr[i+1];
      sr[LEN-1] <= din;
    end
  end

  assign tap_ul = sr[0];
  assign tap_u  = sr[1];
  assign tap_ur = sr[2];
  assign tap_l  = sr[W];
  assign tap_c  = sr[W+1];
  assign tap_r  = sr[W+2];
  assign tap_dl = sr[2*W];
  assign tap_d  = sr[2*W+1];
  assign tap_dr = sr[2*W+2];

endmodule

// File: rtl/hysteresis_filter.sv
// Streaming hysteresis threshold over a 3x3 window,
// FIFO in / FIFO out, one result per two cycles.
module hysteresis_filter
  import hysteresis_pkg::*;
#(
  parameter int WIDTH      = 720,
  parameter int HEIGHT     = 540,
  parameter int PIXEL_BITS = 8,
  parameter int DEF_HIGH   = HYST_DEF_HIGH,
  parameter int DEF_LOW    = HYST_DEF_LOW
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_empty,
  input  logic [PIXEL_BITS-1:0] in_dout,
  output logic                  in_rd_en,
  input  logic                  out_full,
  output logic                  out_wr_en,
  output logic [PIXEL_BITS-1:0] out_din,
  input  logic                  thr_override,
  input  logic [PIXEL_BITS-1:0] high_thr,
  input  logic [PIXEL_BITS-1:0] low_thr,
  output logic                  frame_done
);

  localparam int LEN = 2 * WIDTH + 3;
  localparam int CW  = $clog2(WIDTH);
  localparam int RW  = $clog2(HEIGHT + 1);
  localparam int NW  = $clog2(WIDTH + 3);
  localparam int PW  = $clog2(WIDTH * HEIGHT);

  localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);
  localparam logic [RW-1:0] ROW_END  = RW'(HEIGHT);
  localparam logic [NW-1:0] CNT_LAST = NW'(WIDTH + 1);
  localparam logic [PW-1:0] DRAIN_AT =
    PW'(WIDTH * HEIGHT - WIDTH - 3);

  localparam logic [PIXEL_BITS-1:0] DEF_HI =
    PIXEL_BITS'(DEF_HIGH);
  localparam logic [PIXEL_BITS-1:0] DEF_LO =
    PIXEL_BITS'(DEF_LOW);

  state_t state, nxt;

  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic [NW-1:0] cnt;
  logic [PIXEL_BITS-1:0] result, hi, lo, res;
  logic [PW-1:0] pos;
  logic drain, step, shift_en, border, any_hi, last;
  logic [PIXEL_BITS-1:0] sr_din;
  logic [PIXEL_BITS-1:0] t_ul, t_u, t_ur;
  logic [PIXEL_BITS-1:0] t_l, t_c, t_r;
  logic [PIXEL_BITS-1:0] t_dl, t_d, t_dr;

  window_shift_reg #(
    .LEN        (LEN),
    .PIXEL_BITS (PIXEL_BITS)
  ) u_win (
    .clock    (clock),
    .reset    (reset),
    .shift_en (shift_en),
    .din      (sr_din),
    .tap_ul   (t_ul),
    .tap_u    (t_u),
    .tap_ur   (t_ur),
    .tap_l    (t_l),
    .tap_c    (t_c),
    .tap_r    (t_r),
    .tap_dl   (t_dl),
    .tap_d    (t_d),
    .tap_dr   (t_dr)
  );

  // Once every real pixel is buffered, zeros
  // push the tail of the frame through.
  assign pos   = PW'(row) * PW'(WIDTH) + PW'(col);
  assign drain = pos > DRAIN_AT;
  assign last  = row == ROW_END;
  assign step  = (state == FILTER) &&
                 (!in_empty || drain);
  assign shift_en = step ||
    ((state == PROLOGUE) && !in_empty);
  assign sr_din = (state == FILTER && drain) ?
                  '0 : in_dout;

  always_comb begin
    any_hi = (t_ul > hi) || (t_u > hi) ||
             (t_ur > hi) || (t_l > hi) ||
             (t_r > hi)  || (t_dl > hi) ||
             (t_d > hi)  || (t_dr > hi);
    border = (row == '0) || (row == ROW_LAST) ||
             (col == '0) || (col == COL_LAST);
    res = '0;
    if (!border &&
        ((t_c > hi) || ((t_c > lo) && any_hi)))
      res = t_c;
  end

  always_ff @(posedge clock) begin
    if (reset) state <= PROLOGUE;
    else       state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      PROLOGUE:
        if (!in_empty && cnt == CNT_LAST)
          nxt = FILTER;
      FILTER:
        if (step) nxt = OUTPUT;
      OUTPUT:
        if (!out_full)
          nxt = last ? PROLOGUE : FILTER;
      default: nxt = PROLOGUE;
    endcase
  end

  always_comb begin
    in_rd_en   = 1'b0;
    out_wr_en  = 1'b0;
    out_din    = '0;
    frame_done = 1'b0;
    if (!reset) begin
      unique case (state)
        PROLOGUE: in_rd_en = !in_empty;
        FILTER:   in_rd_en = !in_empty && !drain;
        OUTPUT:
          if (!out_full) begin
            out_wr_en  = 1'b1;
            out_din    = result;
            frame_done = last;
          end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      row    <= '0;
      col    <= '0;
      cnt    <= '0;
      result <= '0;
      hi     <= DEF_HI;
      lo     <= DEF_LO;
    end else begin
      unique case (state)
        PROLOGUE: begin
          hi <= thr_override ? high_thr : DEF_HI;
          lo <= thr_override ? low_thr  : DEF_LO;
          if (!in_empty) cnt <= cnt + 1'b1;
        end
        FILTER:
          if (step) begin
            result <= res;
            if (col == COL_LAST) begin
              col <= '0;
              row <= row + 1'b1;
            end else begin
              col <= col + 1'b1;
            end
          end
        OUTPUT:
          if (!out_full && last) begin
            row    <= '0;
            col    <= '0;
            cnt    <= '0;
            result <= '0;
          end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hysteresis_filter.sv
// Directed bench for hysteresis_filter on a 4x4
// frame with a simple FIFO model on each side.
module tb_hysteresis_filter;

  localparam int W  = 4;
  localparam int H  = 4;
  localparam int PB = 8;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic in_empty;
  logic [PB-1:0] in_dout;
  logic in_rd_en;
  logic out_full = 1'b0;
  logic out_wr_en;
  logic [PB-1:0] out_din;
  logic thr_override = 1'b0;
  logic [PB-1:0] high_thr = '0;
  logic [PB-1:0] low_thr = '0;
  logic frame_done;

  int checks = 0;
  int failures = 0;

  logic [7:0] mem [1024];
  int wp = 0;
  int rp = 0;
  logic hold = 1'b0;
  logic tog = 1'b0;
  logic flush = 1'b0;

  logic [7:0] cap [256];
  int ncap = 0;
  int nfd = 0;

  logic [7:0] pf [16];
  logic [7:0] ef [16];
  int base, fd0;

  hysteresis_filter #(
    .WIDTH      (W),
    .HEIGHT     (H),
    .PIXEL_BITS (PB)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .in_empty     (in_empty),
    .in_dout      (in_dout),
    .in_rd_en     (in_rd_en),
    .out_full     (out_full),
    .out_wr_en    (out_wr_en),
    .out_din      (out_din),
    .thr_override (thr_override),
    .high_thr     (high_thr),
    .low_thr      (low_thr),
    .frame_done   (frame_done)
  );

  always #5 clock = ~clock;

  assign in_empty = hold || (rp == wp);
  assign in_dout  = mem[rp[9:0]];

  always @(posedge clock) begin
    if (flush) rp <= wp;
    else if (in_rd_en) rp <= rp + 1;
    if (tog) hold <= ~hold;
    else     hold <= 1'b0;
  end

  always @(negedge clock) begin
    if (out_wr_en) begin
      cap[ncap[7:0]] = out_din;
      ncap = ncap + 1;
    end
    if (frame_done) nfd = nfd + 1;
  end

  task automatic chk(input string tag,
                     input int obs,
                     input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  task automatic push_pf();
    for (int i = 0; i < 16; i++) begin
      mem[wp[9:0]] = pf[i];
      wp++;
    end
  endtask

  task automatic wait_cap(input int target,
                          input int budget,
                          input string tag);
    int n = 0;
    while (ncap < target && n < budget) begin
      @(posedge clock);
      n++;
    end
    #1;
    chk(tag, ncap, target);
  endtask

  task automatic chk_frame(input string tag,
                           input int b);
    for (int i = 0; i < 16; i++)
      chk($sformatf("%s[%0d]", tag, i),
          cap[b+i], ef[i]);
  endtask

  task automatic set_ramp();
    for (int i = 0; i < 16; i++) pf[i] = 8'(i * 10);
  endtask

  initial begin
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("rst_rd", in_rd_en, 0);
    chk("rst_wr", out_wr_en, 0);
    chk("rst_fd", frame_done, 0);
    chk("rst_din", out_din, 0);

    // uniform 100: only interior survives
    base = ncap; fd0 = nfd;
    pf = '{default: 8'd100};
    push_pf();
    wait_cap(base + 16, 300, "t1_cnt");
    ef = '{0,0,0,0, 0,100,100,0,
           0,100,100,0, 0,0,0,0};
    chk_frame("t1", base);
    repeat (2) @(posedge clock);
    chk("t1_fd", nfd - fd0, 1);

    // weak center linked by a strong neighbour
    base = ncap;
    pf = '{default: 8'd0};
    pf[0] = 8'd60; pf[5] = 8'd30;
    push_pf();
    wait_cap(base + 16, 300, "t2a_cnt");
    ef = '{default: 8'd0};
    ef[5] = 8'd30;
    chk_frame("t2a", base);

    base = ncap;
    pf[0] = 8'd40;
    push_pf();
    wait_cap(base + 16, 300, "t2b_cnt");
    ef = '{default: 8'd0};
    chk_frame("t2b", base);

    // runtime thresholds
    high_thr = 8'd20; low_thr = 8'd5;
    thr_override = 1'b1;
    base = ncap;
    pf = '{default: 8'd0};
    pf[5] = 8'd25; pf[10] = 8'd25;
    push_pf();
    wait_cap(base + 16, 300, "t3a_cnt");
    ef = '{default: 8'd0};
    ef[5] = 8'd25; ef[10] = 8'd25;
    chk_frame("t3a", base);

    base = ncap;
    push_pf();
    wait_cap(base + 3, 300, "t3b_mid");
    thr_override = 1'b0;
    high_thr = 8'd200;
    wait_cap(base + 16, 300, "t3b_cnt");
    chk_frame("t3b", base);

    base = ncap;
    push_pf();
    wait_cap(base + 16, 300, "t3c_cnt");
    ef = '{default: 8'd0};
    chk_frame("t3c", base);

    // downstream stall
    base = ncap;
    pf = '{default: 8'd100};
    push_pf();
    wait_cap(base + 6, 300, "t4_pre");
    out_full = 1'b1;
    @(negedge clock);
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      chk("stall_wr", out_wr_en, 0);
      chk("stall_rd", in_rd_en, 0);
      chk("stall_din", out_din, 0);
    end
    chk("stall_cnt", ncap, base + 6);
    out_full = 1'b0;
    wait_cap(base + 16, 300, "t4_cnt");
    ef = '{0,0,0,0, 0,100,100,0,
           0,100,100,0, 0,0,0,0};
    chk_frame("t4", base);

    // back-to-back frames, bursty input
    base = ncap; fd0 = nfd;
    tog = 1'b1;
    pf = '{default: 8'd100};
    push_pf();
    set_ramp();
    push_pf();
    wait_cap(base + 32, 1500, "t5_cnt");
    tog = 1'b0;
    chk_frame("t5a", base);
    ef = '{0,0,0,0, 0,50,60,0,
           0,90,100,0, 0,0,0,0};
    chk_frame("t5b", base + 16);
    repeat (2) @(posedge clock);
    chk("t5_fd", nfd - fd0, 2);

    // reset abandons a frame
    base = ncap; fd0 = nfd;
    pf = '{default: 8'd100};
    push_pf();
    wait_cap(base + 7, 300, "t6_pre");
    reset = 1'b1; flush = 1'b1;
    @(negedge clock);
    chk("t6_wr0", out_wr_en, 0);
    chk("t6_fd0", frame_done, 0);
    @(posedge clock);
    #1 reset = 1'b0; flush = 1'b0;
    @(negedge clock);
    chk("t6_wr1", out_wr_en, 0);
    chk("t6_fd1", frame_done, 0);
    repeat (30) @(posedge clock);
    chk("t6_quiet", ncap, base + 7);
    chk("t6_nofd", nfd - fd0, 0);

    base = ncap; fd0 = nfd;
    set_ramp();
    push_pf();
    wait_cap(base + 16, 300, "t6_cnt");
    ef = '{0,0,0,0, 0,50,60,0,
           0,90,100,0, 0,0,0,0};
    chk_frame("t6", base);
    repeat (2) @(posedge clock);
    chk("t6_fd", nfd - fd0, 1);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
